// File: rtl/pacman_soc_pulse_pio.sv
// Avalon-MM output PIO with atomic set/clear, a hardware-timed pulse generator
// and a level completion interrupt. out_port is driven only from registers.
module pacman_soc_pulse_pio #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W       = 16,
    parameter int unsigned      PULSE_RST   = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
    localparam logic [2:0] ADDR_PULSE     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
    localparam logic [2:0] ADDR_CTRL      = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LEN_RESET = CNT_W'(PULSE_RST);
    localparam logic [WIDTH-1:0] MASK_ZERO = {WIDTH{1'b0}};

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  data_out_r;
    logic [WIDTH-1:0]  data_nxt_s;
    logic [WIDTH-1:0]  pulse_mask_r;
    logic [WIDTH-1:0]  mask_nxt_s;
    logic [CNT_W-1:0]  pulse_len_r;
    logic [CNT_W-1:0]  len_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CNT_W-1:0]  start_len_s;
    logic              done_r;
    logic              done_nxt_s;
    logic              irq_en_r;
    logic              irq_en_nxt_s;
    logic              busy_s;
    logic              wr_s;
    logic              wr_pulse_s;
    logic              wr_ctrl_s;
    logic [WIDTH-1:0]  wmask_s;
    logic [CNT_W-1:0]  wlen_s;
    logic [31:0]       readdata_s;
    logic              unused_wdata_s;

    assign wr_s        = chipselect & ~write_n;
    assign wr_pulse_s  = wr_s & (address == ADDR_PULSE);
    assign wr_ctrl_s   = wr_s & (address == ADDR_CTRL);
    assign wmask_s     = writedata[WIDTH-1:0];
    assign wlen_s      = writedata[CNT_W-1:0];
    assign busy_s      = (state_r == ST_ACTIVE);
    // A programmed length of zero still yields a single-cycle pulse.
    assign start_len_s = (pulse_len_r == CNT_ZERO) ? CNT_ONE : pulse_len_r;
    assign unused_wdata_s = ^writedata;

    // Data register next value: plain write, atomic set and atomic clear.
    always_comb begin
        data_nxt_s = data_out_r;
        if (wr_s) begin
            case (address)
                ADDR_DATA:     data_nxt_s = wmask_s;
                ADDR_OUTSET:   data_nxt_s = data_out_r | wmask_s;
                ADDR_OUTCLEAR: data_nxt_s = data_out_r & ~wmask_s;
                default:       data_nxt_s = data_out_r;
            endcase
        end else begin
            data_nxt_s = data_out_r;
        end
    end

    // Configuration registers: pulse length and interrupt enable.
    always_comb begin
        len_nxt_s    = pulse_len_r;
        irq_en_nxt_s = irq_en_r;
        if (wr_s && (address == ADDR_PULSE_LEN)) begin
            len_nxt_s = wlen_s;
        end else begin
            len_nxt_s = pulse_len_r;
        end
        if (wr_ctrl_s) begin
            irq_en_nxt_s = writedata[2];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // Pulse FSM next state; completion is applied after the CTRL clear so set wins.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mask_nxt_s  = pulse_mask_r;
        done_nxt_s  = done_r;
        if (wr_ctrl_s && writedata[1]) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (wr_pulse_s && (wmask_s != MASK_ZERO)) begin
                    state_nxt_s = ST_ACTIVE;
                    cnt_nxt_s   = start_len_s;
                    mask_nxt_s  = wmask_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_IDLE;
                    mask_nxt_s  = MASK_ZERO;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                mask_nxt_s  = MASK_ZERO;
            end
        endcase
    end

    // State register; reset mid-pulse aborts without raising done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            data_out_r   <= RESET_VALUE;
            pulse_mask_r <= MASK_ZERO;
            pulse_len_r  <= LEN_RESET;
            cnt_r        <= CNT_ZERO;
            done_r       <= 1'b0;
            irq_en_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            data_out_r   <= data_nxt_s;
            pulse_mask_r <= mask_nxt_s;
            pulse_len_r  <= len_nxt_s;
            cnt_r        <= cnt_nxt_s;
            done_r       <= done_nxt_s;
            irq_en_r     <= irq_en_nxt_s;
        end
    end

    // Zero-wait-state read mux; unused upper bits read as zero.
    always_comb begin
        readdata_s = 32'd0;
        case (address)
            ADDR_DATA:      readdata_s[WIDTH-1:0] = data_out_r;
            ADDR_PULSE_LEN: readdata_s[CNT_W-1:0] = pulse_len_r;
            ADDR_PULSE:     readdata_s[WIDTH-1:0] = pulse_mask_r;
            ADDR_CTRL:      readdata_s = {29'd0, irq_en_r, done_r, busy_s};
            default:        readdata_s = 32'd0;
        endcase
    end

    assign readdata = readdata_s;
    assign out_port = data_out_r ^ pulse_mask_r;
    assign irq      = done_r & irq_en_r;

endmodule

// File: tb/tb_pacman_soc_pulse_pio.sv
// Self-checking bench: directed scenarios plus randomized bus traffic compared
// every cycle against a pulse-window model kept in absolute cycle numbers.
module tb_pacman_soc_pulse_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  out_port;
    logic        irq;

    int n_chk = 0;
    int n_fail = 0;

    pacman_soc_pulse_pio #(
        .WIDTH(4), .RESET_VALUE(4'h5), .CNT_W(16), .PULSE_RST(50000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Model: a pulse is a window of cycles [start, m_end) counted in clock edges.
    logic [3:0]  m_data, m_mask;
    logic [15:0] m_len;
    logic        m_done, m_irq_en;
    int          m_cyc = 0;
    int          m_end = 0;
    bit          m_ok = 1'b0;

    function automatic logic m_busy();
        return m_cyc < m_end;
    endfunction

    function automatic logic [3:0] m_out();
        return m_data ^ (m_busy() ? m_mask : 4'd0);
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0:    return {28'd0, m_data};
            3'd2:    return {16'd0, m_len};
            3'd3:    return {28'd0, (m_busy() ? m_mask : 4'd0)};
            3'd7:    return {29'd0, m_irq_en, m_done, m_busy()};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit busy_pre;
        busy_pre = (m_cyc < m_end);
        m_cyc = m_cyc + 1;
        if (!reset_n) begin
            m_data = 4'h5; m_mask = 4'd0; m_len = 16'd50000;
            m_done = 1'b0; m_irq_en = 1'b0; m_end = 0; m_ok = 1'b1;
        end else begin
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[3:0];
                    3'd2: m_len = writedata[15:0];
                    3'd3: if (!busy_pre && writedata[3:0] != 4'd0) begin
                        m_mask = writedata[3:0];
                        m_end  = m_cyc + ((m_len == 16'd0) ? 1 : int'(m_len));
                    end
                    3'd4: m_data = m_data | writedata[3:0];
                    3'd5: m_data = m_data & ~writedata[3:0];
                    3'd7: begin
                        if (writedata[1]) m_done = 1'b0;
                        m_irq_en = writedata[2];
                    end
                    default: ;
                endcase
            end
            if (busy_pre && m_cyc == m_end) m_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("out_port", {28'd0, out_port}, {28'd0, m_out()});
            chk("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
            chk("readdata", readdata, m_rd(address));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] d);
        address = a; #1; d = readdata;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] tmp;
        logic [2:0]  a;
        int          width_cnt;
        int          r;

        repeat (3) @(posedge clk);
        #1; reset_n = 1'b1;

        // Reset values
        chk("rst_out", {28'd0, out_port}, 32'h5);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        peek(3'd0, d); chk("rst_data", d, 32'h5);
        step(); peek(3'd2, d); chk("rst_len", d, 32'd50000);
        step(); peek(3'd7, d); chk("rst_ctrl", d, 32'd0);
        step();

        // Plain write, atomic set, atomic clear on successive cycles
        wr(3'd0, 32'hFFFF_FFFA); chk("data_wr", {28'd0, out_port}, 32'hA);
        wr(3'd4, 32'h1);         chk("outset", {28'd0, out_port}, 32'hB);
        wr(3'd5, 32'h8);         chk("outclr", {28'd0, out_port}, 32'h3);
        peek(3'd4, d); chk("rd_outset", d, 32'd0);
        step(); peek(3'd5, d); chk("rd_outclr", d, 32'd0);

        // Three-cycle pulse
        wr(3'd2, 32'h3); wr(3'd0, 32'h0); wr(3'd3, 32'h1);
        chk("p3_c1", {28'd0, out_port}, 32'h1);
        peek(3'd7, d); chk("p3_busy", d, 32'h1);
        step(); chk("p3_c2", {28'd0, out_port}, 32'h1);
        step(); chk("p3_c3", {28'd0, out_port}, 32'h1);
        step(); chk("p3_end", {28'd0, out_port}, 32'h0);
        peek(3'd7, d); chk("p3_done", d, 32'h2);

        // Completion interrupt and its clear
        wr(3'd7, 32'h6); chk("irq_clr0", {31'd0, irq}, 32'd0);
        wr(3'd3, 32'h1);
        step(); step(); chk("irq_pre", {31'd0, irq}, 32'd0);
        step(); chk("irq_set", {31'd0, irq}, 32'd1);
        wr(3'd7, 32'h2); chk("irq_clr", {31'd0, irq}, 32'd0);
        peek(3'd7, d); chk("ctrl_clr", d, 32'd0);

        // Zero length gives one cycle; restart mid-pulse is ignored
        wr(3'd2, 32'h0); wr(3'd3, 32'h2);
        chk("p0_c1", {28'd0, out_port}, 32'h2);
        step(); chk("p0_end", {28'd0, out_port}, 32'h0);
        wr(3'd2, 32'd10); wr(3'd3, 32'h1);
        width_cnt = int'(out_port[0]);
        step(); width_cnt += int'(out_port[0]);
        wr(3'd3, 32'h4); width_cnt += int'(out_port[0]);
        chk("p10_nochg", {28'd0, out_port}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            step(); width_cnt += int'(out_port[0]);
        end
        chk("p10_width", width_cnt, 32'd10);

        // Reset aborts a running pulse without done
        wr(3'd3, 32'h1); step();
        chk("p_abort_pre", {28'd0, out_port}, 32'h1);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        chk("abort_out", {28'd0, out_port}, 32'h5);
        peek(3'd7, d); chk("abort_ctrl", d, 32'd0);
        step();

        // Randomized traffic
        wr(3'd2, 32'h2);
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            tmp = $urandom;
            if (r < 2) begin
                reset_n = 1'b0; step(); reset_n = 1'b1;
                wr(3'd2, 32'($urandom_range(0, 5)));
            end else if (r < 55) begin
                a = 3'($urandom_range(0, 7));
                if (a == 3'd2) tmp = {tmp[31:16], 16'($urandom_range(0, 6))};
                wr(a, tmp);
            end else begin
                peek(3'($urandom_range(0, 7)), d);
                step();
            end
        end
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
